// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter run-control sequencer.
package counter_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sequencer_if.sv
// Register/control-side bundle of the counter sequencer: config, commands and status.
interface counter_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PRE_W = 8
);

    logic [WIDTH-1:0] cfg_load_val;
    logic [PRE_W-1:0] cfg_prescale;
    logic             cfg_dir;
    logic             cfg_auto_reload;
    logic             start;
    logic             stop;
    logic             pause;
    logic             irq_ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc_pulse;
    logic             irq;

    modport master (
        output cfg_load_val, cfg_prescale, cfg_dir, cfg_auto_reload,
        output start, stop, pause, irq_ack,
        input  count, busy, done, tc_pulse, irq
    );

    modport slave (
        input  cfg_load_val, cfg_prescale, cfg_dir, cfg_auto_reload,
        input  start, stop, pause, irq_ack,
        output count, busy, done, tc_pulse, irq
    );

endinterface

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: raises tick once every (divisor+1) enabled cycles; holds while disabled.
module tick_prescaler #(
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             clear,
    input  logic [PRE_W-1:0] divisor,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    assign tick = enable && (pre_cnt_q == divisor);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clear) begin
            pre_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
        end else if (enable) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer for a WIDTH-bit counter: start/stop/pause sequencing,
// prescaled stepping, terminal-count detection and a sticky interrupt.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PRE_W = 8
) (
    input logic                clk,
    input logic                rstn,
    counter_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sh_load_q, sh_load_d;
    logic [PRE_W-1:0] sh_pre_q, sh_pre_d;
    logic             sh_dir_q, sh_dir_d;
    logic             sh_auto_q, sh_auto_d;

    logic             start_ok;
    logic             pre_enable;
    logic             pre_clear;
    logic             tick;
    logic [WIDTH-1:0] terminal;

    // Up runs 0 -> load_val, down runs load_val -> 0; the range never crosses a wrap.
    function automatic logic [WIDTH-1:0] start_value(input logic dir,
                                                     input logic [WIDTH-1:0] load_val);
        return (dir == DIR_DOWN) ? load_val : '0;
    endfunction

    assign terminal   = (sh_dir_q == DIR_UP) ? sh_load_q : '0;
    assign start_ok   = bus.start && !bus.stop && ((state_q == StIdle) || (state_q == StDone));
    assign pre_enable = (state_q == StRun) && !bus.pause && !bus.stop;
    assign pre_clear  = bus.stop || start_ok;

    tick_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk    (clk),
        .rstn   (rstn),
        .enable (pre_enable),
        .clear  (pre_clear),
        .divisor(sh_pre_q),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tc_d      = 1'b0;
        irq_d     = irq_q;
        sh_load_d = sh_load_q;
        sh_pre_d  = sh_pre_q;
        sh_dir_d  = sh_dir_q;
        sh_auto_d = sh_auto_q;

        // Ack is applied first so a coincident terminal count below overrides it.
        if (bus.irq_ack) begin
            irq_d = 1'b0;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (bus.start) begin
                    sh_load_d = bus.cfg_load_val;
                    sh_pre_d  = bus.cfg_prescale;
                    sh_dir_d  = bus.cfg_dir;
                    sh_auto_d = bus.cfg_auto_reload;
                    count_d   = start_value(bus.cfg_dir, bus.cfg_load_val);
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (bus.pause) begin
                    state_d = StPaused;
                end else if (tick) begin
                    if (count_q == terminal) begin
                        tc_d  = 1'b1;
                        irq_d = 1'b1;
                        if (sh_auto_q) begin
                            count_d = start_value(sh_dir_q, sh_load_q);
                        end else begin
                            state_d = StDone;
                        end
                    end else if (sh_dir_q == DIR_UP) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            StPaused: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (!bus.pause) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            count_q   <= '0;
            tc_q      <= 1'b0;
            irq_q     <= 1'b0;
            sh_load_q <= '0;
            sh_pre_q  <= '0;
            sh_dir_q  <= 1'b0;
            sh_auto_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            irq_q     <= irq_d;
            sh_load_q <= sh_load_d;
            sh_pre_q  <= sh_pre_d;
            sh_dir_q  <= sh_dir_d;
            sh_auto_q <= sh_auto_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.busy     = (state_q == StRun) || (state_q == StPaused);
    assign bus.done     = (state_q == StDone);
    assign bus.tc_pulse = tc_q;
    assign bus.irq      = irq_q;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run-control block for the team's 4-bit counters. Loads a start value and steps the count up or down at a programmable prescaled rate. Detects the terminal count and raises a sticky interrupt, in one-shot or auto-reload mode. Sits between a register/control interface and the counter datapath, replacing free-running ripple operation with start/stop/pause sequencing.

Parameters:
WIDTH, 4, count width in bits
PRE_W, 8, prescaler width; step rate = clk / (prescale+1)

Ports:
clk  in  1  single system clock; all state on rising edge
rstn  in  1  asynchronous active-low reset
cfg_load_val  in  WIDTH  terminal value (up mode) / start value (down mode)
cfg_prescale  in  PRE_W  prescale divisor minus one
cfg_dir  in  1  1 = count up, 0 = count down
cfg_auto_reload  in  1  1 = reload on terminal count and continue, 0 = one-shot
start  in  1  single-cycle command: begin a run
stop  in  1  single-cycle command: abort to IDLE
pause  in  1  level; while high in RUN, stepping is frozen
irq_ack  in  1  single-cycle clear of irq
count  out  WIDTH  current count value
busy  out  1  high in RUN or PAUSED
done  out  1  high in DONE
tc_pulse  out  1  one-cycle pulse on terminal-count step
irq  out  1  sticky terminal-count interrupt

Behaviour:
- Clock/reset: one clock, clk; reset rstn is asynchronous, active-low.
- Reset values: state=IDLE, count=0, prescale counter=0, shadow config=0, busy=0, done=0, tc_pulse=0, irq=0.
- States: IDLE, RUN, PAUSED, DONE. busy = (RUN|PAUSED); done = (DONE).
- Config capture: at an accepted start, cfg_* are copied to shadow registers. cfg changes mid-run have no effect.
- Start value: up mode starts at 0 with terminal cfg_load_val. Down mode starts at cfg_load_val with terminal 0.
- IDLE/DONE + start: count <= start value, prescale counter <= 0, next state RUN.
- RUN + start: ignored. A restart requires stop first.
- Prescaler: counts only in RUN. A tick occurs in a RUN cycle where pre_cnt == shadow_prescale, and pre_cnt then wraps to 0. With prescale=0, every RUN cycle is a tick.
- Latency: start accepted at edge N puts count at start value after N. With prescale=P, the first step is visible after edge N+P+1.
- Tick, count != terminal: count +/-1 per dir.
- Tick, count == terminal: tc_pulse=1 for the next cycle and irq <= 1.
  - auto_reload=1: count <= start value, stay RUN.
  - auto_reload=0: count holds terminal, go DONE.
- cfg_load_val=0: the terminal is reached on the first tick in either direction. No arithmetic wrap ever occurs.
- PAUSED: entered from RUN when pause=1. pre_cnt and count freeze. Returns to RUN when pause=0 and resumes from the frozen pre_cnt. A tick cannot occur in the cycle pause is sampled high.
- stop: highest priority, from RUN/PAUSED/DONE goes to IDLE. count retains its value, pre_cnt <= 0, irq is unaffected. When start and stop arrive in the same cycle, stop wins and the block stays in IDLE.
- irq: set by terminal count, cleared by irq_ack. When set and ack arrive in the same cycle, set wins.
- Reset mid-run: immediate return to reset values, independent of clk.
- tc_pulse is registered. It is never high for two consecutive cycles unless prescale=0 with auto-reload at load_val=0. In that case it is high continuously, which is legal.

Decomposition:
- Package counter_sequencer_pkg:
  - state enum (IDLE, RUN, PAUSED, DONE)
  - DIR_UP=1, DIR_DOWN=0
- Sub-module tick_prescaler (PRE_W): inputs enable, clear, divisor; output tick. Owns pre_cnt.
- FSM, shadow registers, count and irq logic stay in counter_sequencer.

Test Plan:
- Reset: assert rstn=0 mid-RUN, with count=5 -> all outputs 0 asynchronously; state IDLE after release.
- Up one-shot: load_val=3, prescale=0, dir=1, start -> count 0,1,2,3. tc_pulse one cycle after the step at count=3. irq=1, done=1, count holds 3.
- Down auto-reload with prescale: load_val=2, prescale=2, dir=0 -> count steps every 3 cycles: 2,1,0,2,1,0. tc_pulse on each terminal step. busy stays 1.
- Pause/stop: pause high for 5 cycles mid-run -> count and prescale frozen, then resume with the correct remaining interval. start and stop in the same cycle -> stays IDLE. stop in RUN -> IDLE with count held.
- irq handshake: irq_ack coincident with a terminal step -> irq remains 1. A later irq_ack alone -> irq=0.
- Edge values: load_val=0 -> tc on the first tick. load_val=15 up with WIDTH=4 -> terminal 15, no wrap to 0. cfg changes during RUN -> no effect.
